uart_rx_os16: RTL and testbench

//   UART 8N1 receiver using 16x oversampling. Deserialises the asynchronous rx line into bytes.

---
 rtl/uart_rx_os16.sv | 144 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - UART 8N1 receiver with 16x oversampling
// Mid-bit sampling of a synchronised rx line; one-cycle valid / framing-error strobes.
module uart_rx_os16 #(
  parameter int CLK_TICKS = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int TW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t       state_q, state_d;
  logic         rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q;
  logic         tick;
  logic [3:0]   os_cnt_q, os_cnt_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   data_q, data_d;
  logic         valid_q, valid_d;
  logic         ferr_q, ferr_d;

  assign tick = (tick_cnt_q == TW'(CLK_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d  = S_START;
            os_cnt_d = '0;
          end
        end
        S_START: begin
          // Re-check at mid start bit so short low glitches are rejected.
          if (os_cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d   = S_DATA;
              os_cnt_d  = '0;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (os_cnt_q == 4'd15) begin
            shift_d[bit_idx_q] = rx_s_q;
            os_cnt_d           = '0;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (os_cnt_q == 4'd15) begin
            os_cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - directed self-checking bench for uart_rx_os16
// Short tick period keeps frames small; all timing scales with BIT.
module tb_uart_rx_os16;

  localparam int CLK_TICKS = 4;
  localparam int BIT       = 16 * CLK_TICKS;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  int n_long  = 0;
  int exp_nv  = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] hello[5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [7:0] bounds[4] = '{8'h00, 8'hFF, 8'h01, 8'h80};

  uart_rx_os16 #(.CLK_TICKS(CLK_TICKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      cap.push_back(data);
    end
    if (frame_err) n_ferr++;
    if (data_valid && frame_err) n_both++;
    if ((data_valid && prev_v) || (frame_err && prev_f)) n_long++;
    prev_v = data_valid;
    prev_f = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nslots);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < nslots; i++) begin
      rx = fr[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      send_frame(hello[i], 1'b1, 10);
      idle(3);
      exp_nv++;
      check("hello_count", 32'(n_valid), 32'(exp_nv));
      check("hello_data", 32'(data), 32'(hello[i]));
    end
    check("hello_no_ferr", 32'(n_ferr), 32'd0);

    rx = 1'b0;
    repeat (4 * CLK_TICKS) @(negedge clk);
    idle(3);
    check("glitch_count", 32'(n_valid), 32'(exp_nv));
    check("glitch_data", 32'(data), 32'h4F);
    check("glitch_ferr", 32'(n_ferr), 32'd0);

    send_frame(8'hA5, 1'b0, 10);
    check("ferr_pulse", 32'(n_ferr), 32'd1);
    check("ferr_data_kept", 32'(data), 32'h4F);
    repeat (20 * BIT) @(negedge clk);
    check("break_ferr", 32'(n_ferr), 32'd1);
    check("break_count", 32'(n_valid), 32'(exp_nv));
    idle(2);
    send_frame(8'h3C, 1'b1, 10);
    idle(2);
    exp_nv++;
    check("after_ferr_count", 32'(n_valid), 32'(exp_nv));
    check("after_ferr_data", 32'(data), 32'h3C);

    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    idle(2);
    exp_nv += 2;
    check("b2b_count", 32'(n_valid), 32'(exp_nv));
    check("b2b_first", 32'(cap[cap.size()-2]), 32'h00);
    check("b2b_second", 32'(cap[cap.size()-1]), 32'hFF);

    send_frame(8'h55, 1'b1, 4);
    repeat (BIT / 2) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_count", 32'(n_valid), 32'(exp_nv));
    send_frame(8'h81, 1'b1, 10);
    idle(2);
    exp_nv++;
    check("post_rst_count", 32'(n_valid), 32'(exp_nv));
    check("post_rst_data", 32'(data), 32'h81);

    for (int i = 0; i < 4; i++) begin
      send_frame(bounds[i], 1'b1, 10);
      idle(2);
      exp_nv++;
      check("bound_count", 32'(n_valid), 32'(exp_nv));
      check("bound_data", 32'(data), 32'(bounds[i]));
    end

    check("never_both", 32'(n_both), 32'd0);
    check("single_cycle_pulses", 32'(n_long), 32'd0);
    check("total_ferr", 32'(n_ferr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
